// File: rtl/multi_cycle_control_unit_if.sv
// Control bundle between the multi-cycle control FSM and its datapath.
// The control unit is the master: it consumes op/flags, drives every select.
interface multi_cycle_control_unit_if;
    logic [5:0] op;
    logic       Zero;
    logic       Sign;
    logic [2:0] State;
    logic       PCWre;
    logic       IRWre;
    logic       InsMemRW;
    logic       mRD;
    logic       mWR;
    logic       RegWre;
    logic       ALUSrcA;
    logic       ALUSrcB;
    logic       DBDataSrc;
    logic       WrRegDSrc;
    logic       ExtSel;
    logic [1:0] RegDst;
    logic [1:0] PCSrc;
    logic [2:0] ALUOp;

    modport master (
        input  op, Zero, Sign,
        output State, PCWre, IRWre, InsMemRW, mRD, mWR, RegWre,
        output ALUSrcA, ALUSrcB, DBDataSrc, WrRegDSrc, ExtSel,
        output RegDst, PCSrc, ALUOp
    );

    modport slave (
        output op, Zero, Sign,
        input  State, PCWre, IRWre, InsMemRW, mRD, mWR, RegWre,
        input  ALUSrcA, ALUSrcB, DBDataSrc, WrRegDSrc, ExtSel,
        input  RegDst, PCSrc, ALUOp
    );
endinterface

// File: rtl/multi_cycle_control_unit.sv
// Multi-cycle CPU control FSM: IF/ID/EXE/MEM/WB sequencing plus
// datapath select/enable decode from the current state and IR opcode.
module multi_cycle_control_unit #(
    parameter logic [5:0] OP_HALT = 6'b111111,
    parameter logic [1:0] RA_SEL  = 2'b00
) (
    input  logic                        CLK,
    input  logic                        Reset,
    multi_cycle_control_unit_if.master  bus
);

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_ADDIU = 6'b000010;
    localparam logic [5:0] OP_ANDI  = 6'b010000;
    localparam logic [5:0] OP_AND   = 6'b010001;
    localparam logic [5:0] OP_ORI   = 6'b010010;
    localparam logic [5:0] OP_OR    = 6'b010011;
    localparam logic [5:0] OP_SLL   = 6'b011000;
    localparam logic [5:0] OP_SLTI  = 6'b011100;
    localparam logic [5:0] OP_SW    = 6'b100110;
    localparam logic [5:0] OP_LW    = 6'b100111;
    localparam logic [5:0] OP_BEQ   = 6'b110000;
    localparam logic [5:0] OP_BNE   = 6'b110001;
    localparam logic [5:0] OP_BLTZ  = 6'b110010;
    localparam logic [5:0] OP_J     = 6'b111000;
    localparam logic [5:0] OP_JR    = 6'b111001;
    localparam logic [5:0] OP_JAL   = 6'b111010;

    typedef enum logic [2:0] {
        S_IF     = 3'b000,
        S_ID     = 3'b001,
        S_EXE_LS = 3'b010,
        S_MEM    = 3'b011,
        S_WB_LD  = 3'b100,
        S_EXE_BR = 3'b101,
        S_EXE_AL = 3'b110,
        S_WB_AL  = 3'b111
    } state_t;

    state_t state_q;
    state_t state_d;

    logic is_add, is_sub, is_addiu, is_andi, is_and, is_ori;
    logic is_or, is_sll, is_slti, is_sw, is_lw;
    logic is_beq, is_bne, is_bltz, is_j, is_jr, is_jal;
    logic is_halt;

    logic is_branch;
    logic is_ls;
    logic is_alu;
    logic is_imm;
    logic is_rtype;
    logic is_itype_wr;
    logic is_known;
    logic br_taken;
    logic pc_wre;
    logic [2:0] alu_op;

    // One-hot opcode decode of the IR field (held stable after IF)
    always_comb begin
        is_add   = 1'b0;
        is_sub   = 1'b0;
        is_addiu = 1'b0;
        is_andi  = 1'b0;
        is_and   = 1'b0;
        is_ori   = 1'b0;
        is_or    = 1'b0;
        is_sll   = 1'b0;
        is_slti  = 1'b0;
        is_sw    = 1'b0;
        is_lw    = 1'b0;
        is_beq   = 1'b0;
        is_bne   = 1'b0;
        is_bltz  = 1'b0;
        is_j     = 1'b0;
        is_jr    = 1'b0;
        is_jal   = 1'b0;
        case (bus.op)
            OP_ADD:   is_add   = 1'b1;
            OP_SUB:   is_sub   = 1'b1;
            OP_ADDIU: is_addiu = 1'b1;
            OP_ANDI:  is_andi  = 1'b1;
            OP_AND:   is_and   = 1'b1;
            OP_ORI:   is_ori   = 1'b1;
            OP_OR:    is_or    = 1'b1;
            OP_SLL:   is_sll   = 1'b1;
            OP_SLTI:  is_slti  = 1'b1;
            OP_SW:    is_sw    = 1'b1;
            OP_LW:    is_lw    = 1'b1;
            OP_BEQ:   is_beq   = 1'b1;
            OP_BNE:   is_bne   = 1'b1;
            OP_BLTZ:  is_bltz  = 1'b1;
            OP_J:     is_j     = 1'b1;
            OP_JR:    is_jr    = 1'b1;
            OP_JAL:   is_jal   = 1'b1;
            default:  ;
        endcase
        is_halt = (bus.op == OP_HALT);
    end

    assign is_branch   = is_beq | is_bne | is_bltz;
    assign is_ls       = is_lw | is_sw;
    assign is_alu      = is_add | is_sub | is_addiu | is_andi | is_and
                       | is_ori | is_or | is_sll | is_slti;
    assign is_imm      = is_addiu | is_andi | is_ori | is_slti | is_ls;
    assign is_rtype    = is_add | is_sub | is_and | is_or | is_sll;
    assign is_itype_wr = is_addiu | is_andi | is_ori | is_slti | is_lw;
    assign is_known    = is_alu | is_ls | is_branch
                       | is_j | is_jr | is_jal | is_halt;

    assign br_taken = (is_beq & bus.Zero)
                    | (is_bne & ~bus.Zero)
                    | (is_bltz & bus.Sign);

    // ALU function select; unknown opcodes fall back to add
    always_comb begin
        alu_op = 3'b000;
        case (1'b1)
            is_sub | is_branch: alu_op = 3'b001;
            is_sll:             alu_op = 3'b010;
            is_or | is_ori:     alu_op = 3'b011;
            is_and | is_andi:   alu_op = 3'b100;
            is_slti:            alu_op = 3'b101;
            default:            alu_op = 3'b000;
        endcase
    end

    // Next-state: one step per clock, ID and MEM branch on opcode class
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IF:     state_d = S_ID;
            S_ID: begin
                if (is_branch)   state_d = S_EXE_BR;
                else if (is_ls)  state_d = S_EXE_LS;
                else if (is_alu) state_d = S_EXE_AL;
                else             state_d = S_IF;
            end
            S_EXE_AL: state_d = S_WB_AL;
            S_WB_AL:  state_d = S_IF;
            S_EXE_BR: state_d = S_IF;
            S_EXE_LS: state_d = S_MEM;
            S_MEM:    state_d = is_lw ? S_WB_LD : S_IF;
            S_WB_LD:  state_d = S_IF;
            default:  state_d = S_IF;
        endcase
    end

    // State register with synchronous reset into IF
    always_ff @(posedge CLK) begin
        if (Reset) state_q <= S_IF;
        else       state_q <= state_d;
    end

    // PC update happens only in the last cycle of every non-halt instruction
    always_comb begin
        pc_wre = 1'b0;
        unique case (state_q)
            S_ID:     pc_wre = is_j | is_jr | is_jal | ~is_known;
            S_EXE_BR: pc_wre = 1'b1;
            S_MEM:    pc_wre = is_sw;
            S_WB_AL:  pc_wre = 1'b1;
            S_WB_LD:  pc_wre = 1'b1;
            default:  pc_wre = 1'b0;
        endcase
    end

    // Output decode; everything forced low while Reset is asserted
    always_comb begin
        bus.State     = 3'b000;
        bus.PCWre     = 1'b0;
        bus.IRWre     = 1'b0;
        bus.InsMemRW  = 1'b0;
        bus.mRD       = 1'b0;
        bus.mWR       = 1'b0;
        bus.RegWre    = 1'b0;
        bus.ALUSrcA   = 1'b0;
        bus.ALUSrcB   = 1'b0;
        bus.DBDataSrc = 1'b0;
        bus.WrRegDSrc = 1'b0;
        bus.ExtSel    = 1'b0;
        bus.RegDst    = 2'b00;
        bus.PCSrc     = 2'b00;
        bus.ALUOp     = 3'b000;
        if (!Reset) begin
            bus.State    = state_q;
            bus.InsMemRW = 1'b1;
            bus.IRWre    = (state_q == S_IF);
            bus.PCWre    = pc_wre;
            bus.mRD      = (state_q == S_MEM) & is_lw;
            bus.mWR      = (state_q == S_MEM) & is_sw;
            bus.RegWre   = (state_q == S_WB_AL)
                         | (state_q == S_WB_LD)
                         | ((state_q == S_ID) & is_jal);
            // op is stale during IF, so selects only follow it afterwards
            if (state_q != S_IF) begin
                bus.ALUSrcA   = is_sll;
                bus.ALUSrcB   = is_imm;
                bus.DBDataSrc = is_lw;
                bus.WrRegDSrc = ~is_jal;
                bus.ExtSel    = ~(is_andi | is_ori);
                bus.ALUOp     = alu_op;
                if (is_jal)           bus.RegDst = RA_SEL;
                else if (is_itype_wr) bus.RegDst = 2'b01;
                else if (is_rtype)    bus.RegDst = 2'b10;
                else                  bus.RegDst = 2'b00;
            end
            if (pc_wre) begin
                if (is_j | is_jal)
                    bus.PCSrc = 2'b11;
                else if (is_jr)
                    bus.PCSrc = 2'b10;
                else if ((state_q == S_EXE_BR) & br_taken)
                    bus.PCSrc = 2'b01;
                else
                    bus.PCSrc = 2'b00;
            end
        end
    end

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// Scoreboard bench for the multi-cycle control FSM: per-cycle expected
// output vectors are queued per instruction and popped each cycle.
module tb_multi_cycle_control_unit;

    typedef struct packed {
        logic [2:0] st;
        logic       pcwre;
        logic       irwre;
        logic       imrw;
        logic       mrd;
        logic       mwr;
        logic       regwre;
        logic       asa;
        logic       asb;
        logic       dbs;
        logic       wrs;
        logic       ext;
        logic [1:0] rdst;
        logic [1:0] pcsrc;
        logic [2:0] aluop;
    } vec_t;

    localparam logic [5:0] ADD   = 6'b000000;
    localparam logic [5:0] SUB   = 6'b000001;
    localparam logic [5:0] ADDIU = 6'b000010;
    localparam logic [5:0] ANDI  = 6'b010000;
    localparam logic [5:0] AND_  = 6'b010001;
    localparam logic [5:0] ORI   = 6'b010010;
    localparam logic [5:0] OR_   = 6'b010011;
    localparam logic [5:0] SLL   = 6'b011000;
    localparam logic [5:0] SLTI  = 6'b011100;
    localparam logic [5:0] SW    = 6'b100110;
    localparam logic [5:0] LW    = 6'b100111;
    localparam logic [5:0] BEQ   = 6'b110000;
    localparam logic [5:0] BNE   = 6'b110001;
    localparam logic [5:0] BLTZ  = 6'b110010;
    localparam logic [5:0] J     = 6'b111000;
    localparam logic [5:0] JR    = 6'b111001;
    localparam logic [5:0] JAL   = 6'b111010;
    localparam logic [5:0] HALT  = 6'b111111;
    localparam logic [5:0] UNK   = 6'b000111;

    logic CLK;
    logic Reset;
    int   n_vec;
    int   n_err;

    vec_t  exp_q[$];
    vec_t  msk_q[$];
    string tag_q[$];

    multi_cycle_control_unit_if bus ();

    multi_cycle_control_unit dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [20:0] got,
                       input logic [20:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got %h want %h", tag, got, want);
        end
    endtask

    function automatic vec_t sample();
        vec_t v;
        v.st     = bus.State;
        v.pcwre  = bus.PCWre;
        v.irwre  = bus.IRWre;
        v.imrw   = bus.InsMemRW;
        v.mrd    = bus.mRD;
        v.mwr    = bus.mWR;
        v.regwre = bus.RegWre;
        v.asa    = bus.ALUSrcA;
        v.asb    = bus.ALUSrcB;
        v.dbs    = bus.DBDataSrc;
        v.wrs    = bus.WrRegDSrc;
        v.ext    = bus.ExtSel;
        v.rdst   = bus.RegDst;
        v.pcsrc  = bus.PCSrc;
        v.aluop  = bus.ALUOp;
        return v;
    endfunction

    function automatic bit is_br(input logic [5:0] o);
        return o == BEQ || o == BNE || o == BLTZ;
    endfunction

    function automatic bit is_al(input logic [5:0] o);
        return o == ADD || o == SUB || o == ADDIU || o == ANDI
            || o == AND_ || o == ORI || o == OR_ || o == SLL
            || o == SLTI;
    endfunction

    function automatic int inst_len(input logic [5:0] o);
        if (o == LW)        return 5;
        if (o == SW)        return 4;
        if (is_al(o))       return 4;
        if (is_br(o))       return 3;
        return 2;
    endfunction

    function automatic logic [2:0] exp_state(input logic [5:0] o,
                                             input int i);
        if (i == 0) return 3'b000;
        if (i == 1) return 3'b001;
        if (is_br(o)) return 3'b101;
        if (is_al(o)) return (i == 2) ? 3'b110 : 3'b111;
        case (i)
            2:       return 3'b010;
            3:       return 3'b011;
            default: return 3'b100;
        endcase
    endfunction

    function automatic logic [2:0] exp_aluop(input logic [5:0] o);
        case (o)
            SUB, BEQ, BNE, BLTZ: return 3'b001;
            SLL:                 return 3'b010;
            OR_, ORI:            return 3'b011;
            AND_, ANDI:          return 3'b100;
            SLTI:                return 3'b101;
            default:             return 3'b000;
        endcase
    endfunction

    // Expected outputs and compare mask for cycle i of instruction o
    task automatic model(input logic [5:0] o, input int i,
                         input logic z, input logic s,
                         output vec_t e, output vec_t m);
        int  len;
        bit  last;
        bit  taken;
        len   = inst_len(o);
        last  = (i == len - 1);
        taken = (o == BEQ && z) || (o == BNE && !z)
             || (o == BLTZ && s);
        e = '0;
        m = '0;
        m.st = 3'b111;
        {m.pcwre, m.irwre, m.imrw, m.mrd, m.mwr, m.regwre} = 6'h3f;
        e.st     = exp_state(o, i);
        e.imrw   = 1'b1;
        e.irwre  = (i == 0);
        e.pcwre  = last && (o != HALT);
        e.regwre = (last && (is_al(o) || o == LW))
                || (i == 1 && o == JAL);
        e.mrd    = (i == 3) && (o == LW);
        e.mwr    = (i == 3) && (o == SW);
        if (e.pcwre) begin
            m.pcsrc = 2'b11;
            if (o == J || o == JAL) e.pcsrc = 2'b11;
            else if (o == JR)       e.pcsrc = 2'b10;
            else if (taken)         e.pcsrc = 2'b01;
            else                    e.pcsrc = 2'b00;
        end
        if (i >= 2) begin
            {m.asa, m.asb, m.ext} = 3'b111;
            m.aluop = 3'b111;
            e.asa   = (o == SLL);
            e.asb   = (o == ADDIU || o == ANDI || o == ORI
                    || o == SLTI || o == LW || o == SW);
            e.ext   = !(o == ANDI || o == ORI);
            e.aluop = exp_aluop(o);
        end
        if (e.regwre) begin
            {m.dbs, m.wrs} = 2'b11;
            m.rdst = 2'b11;
            e.dbs  = (o == LW);
            e.wrs  = (o != JAL);
            if (o == JAL)
                e.rdst = 2'b00;
            else if (o == ADDIU || o == ANDI || o == ORI
                     || o == SLTI || o == LW)
                e.rdst = 2'b01;
            else
                e.rdst = 2'b10;
        end
    endtask

    task automatic push(input string tag, input vec_t e, input vec_t m);
        exp_q.push_back(e);
        msk_q.push_back(m);
        tag_q.push_back(tag);
    endtask

    task automatic pop_cmp();
        vec_t  e;
        vec_t  m;
        vec_t  g;
        string t;
        #1;
        g = sample();
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL sb_empty got %h want none", g);
        end else begin
            e = exp_q.pop_front();
            m = msk_q.pop_front();
            t = tag_q.pop_front();
            chk(t, g & m, e & m);
        end
    endtask

    // Run ncyc cycles (0 = whole instruction), entering on a negedge in IF
    task automatic run(input string nm, input logic [5:0] o,
                       input logic z, input logic s, input int ncyc);
        vec_t e;
        vec_t m;
        int   n;
        n = (ncyc == 0) ? inst_len(o) : ncyc;
        for (int i = 0; i < n; i++) begin
            model(o, i, z, s, e, m);
            push($sformatf("%s.c%0d", nm, i), e, m);
        end
        bus.op   = o;
        bus.Zero = z;
        bus.Sign = s;
        for (int i = 0; i < n; i++) begin
            pop_cmp();
            @(negedge CLK);
        end
    endtask

    task automatic expect_zero(input string nm);
        vec_t m;
        m = '1;
        push(nm, '0, m);
        pop_cmp();
    endtask

    logic [5:0] pool [12];

    initial begin
        n_vec    = 0;
        n_err    = 0;
        Reset    = 1'b1;
        bus.op   = ADD;
        bus.Zero = 1'b0;
        bus.Sign = 1'b0;
        pool = '{ADD, SUB, ADDIU, ANDI, ORI, SLL,
                 SLTI, SW, LW, BEQ, BNE, JAL};

        @(negedge CLK);
        expect_zero("rst0");
        @(negedge CLK);
        expect_zero("rst1");
        @(negedge CLK);
        Reset = 1'b0;

        run("add_abort", ADD, 1'b0, 1'b0, 3);
        Reset = 1'b1;
        expect_zero("abort0");
        @(negedge CLK);
        expect_zero("abort1");
        @(negedge CLK);
        Reset = 1'b0;

        run("add", ADD, 1'b0, 1'b0, 0);
        run("lw", LW, 1'b0, 1'b0, 0);
        run("sw", SW, 1'b0, 1'b0, 0);
        run("beq_t", BEQ, 1'b1, 1'b0, 0);
        run("beq_n", BEQ, 1'b0, 1'b0, 0);
        run("bne_t", BNE, 1'b0, 1'b0, 0);
        run("bne_n", BNE, 1'b1, 1'b0, 0);
        run("bltz_t", BLTZ, 1'b0, 1'b1, 0);
        run("bltz_n", BLTZ, 1'b1, 1'b0, 0);
        run("j", J, 1'b0, 1'b0, 0);
        run("jr", JR, 1'b0, 1'b0, 0);
        run("jal", JAL, 1'b0, 1'b0, 0);
        for (int k = 0; k < 5; k++)
            run($sformatf("halt%0d", k), HALT, 1'b0, 1'b0, 0);
        run("andi", ANDI, 1'b0, 1'b0, 0);
        run("sll", SLL, 1'b0, 1'b0, 0);
        run("sub", SUB, 1'b0, 1'b0, 0);
        run("addiu", ADDIU, 1'b0, 1'b0, 0);
        run("and", AND_, 1'b0, 1'b0, 0);
        run("ori", ORI, 1'b0, 1'b0, 0);
        run("or", OR_, 1'b0, 1'b0, 0);
        run("slti", SLTI, 1'b0, 1'b0, 0);
        run("unk", UNK, 1'b0, 1'b0, 0);

        for (int k = 0; k < 20; k++) begin
            logic [5:0] o;
            logic       z;
            logic       s;
            o = pool[$urandom_range(0, 11)];
            z = 1'($urandom_range(0, 1));
            s = 1'($urandom_range(0, 1));
            run($sformatf("rnd%0d_%b", k, o), o, z, s, 0);
        end

        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL sb_left got %0d want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
